spi_slave_tx_arbiter: RTL and testbench
=======================================

Name: spi_slave_tx_arbiter

Overview:
Round-robin arbiter that shares the source (write) side of the SPI slave dual-clock FIFO among NUM_REQ on-chip requesters in the FIFO's source clock domain.
Grants one requester at a time for a burst that ends on a last flag, a word limit or an inactivity timeout.
It then rotates priority.
Sits between the register/DMA producers and the FIFO's data/valid/ready input.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
DATA_WIDTH, 32, word width; matches the FIFO data width
MAX_BURST, 4, maximum words per grant (>=1)
IDLE_TIMEOUT, 8, consecutive cycles with the granted requester's valid low before the grant is revoked (>=1)

Ports:
clk  in  1  clock; same clock as the FIFO source side
rst  in  1  reset; one clock; reset is asynchronous and active-high
req_data  in  NUM_REQ*DATA_WIDTH  packed request words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_valid  in  NUM_REQ  per-requester valid
req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by valid
req_ready  out  NUM_REQ  per-requester ready
fifo_data  out  DATA_WIDTH  word to the FIFO
fifo_valid  out  1  valid to the FIFO
fifo_ready  in  1  ready from the FIFO
grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grantee
busy  out  1  high while in state GRANT

Behaviour:
- Reset values: state IDLE; rr_ptr = NUM_REQ-1, so requester 0 has first priority; beat_cnt = 0; idle_cnt = 0; grant_id = 0; busy = 0.
- Outputs while in reset or IDLE: fifo_valid = 0; req_ready = 0.
- A transfer occurs on a cycle where fifo_valid && fifo_ready.
- IDLE state:
  - If any req_valid bit is set, select the first set index searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - Register that index into grant_id and go to GRANT.
  - Clear beat_cnt and idle_cnt.
  - Arbitration is registered: first word reaches the FIFO no earlier than 1 cycle after the request.
- GRANT state, g = grant_id:
  - fifo_data = req_data[g]; fifo_valid = req_valid[g]; req_ready[g] = fifo_ready. All other req_ready bits are 0. These are combinational paths, adding no latency.
  - On each transfer, beat_cnt increments.
  - Exit to IDLE when a transfer occurs with req_last[g] = 1, or with beat_cnt == MAX_BURST-1.
  - On exit, set rr_ptr = g.
- Timeout:
  - In GRANT, idle_cnt increments each cycle req_valid[g] is 0; it clears when req_valid[g] is 1.
  - When idle_cnt reaches IDLE_TIMEOUT-1 with valid still low, exit to IDLE and set rr_ptr = g.
  - No transfer occurs on that cycle.
- Every burst is followed by one IDLE cycle (arbitration bubble). Consecutive bursts to the FIFO are therefore separated by at least 1 cycle with fifo_valid = 0.
- Backpressure: while fifo_ready = 0, fifo_valid holds but beat_cnt does not advance. idle_cnt does not advance while valid is high, so a full FIFO never triggers a timeout.
- Simultaneous last and MAX_BURST on the same transfer: single exit, no double counting.
- Requester protocol: valid must not drop before acceptance. Non-granted requesters are unaffected by the grant and keep their valid asserted.
- Reset asserted mid-burst: immediate return to reset values. The word in flight is not transferred; the requester retries after reset.
- beat_cnt width is $clog2(MAX_BURST+1); idle_cnt width is $clog2(IDLE_TIMEOUT+1). Neither counter may wrap.
- grant_id holds its value in IDLE.

Test Plan:
- Reset, then requester 0 sends 3 words (A0,A1,A2; last on A2) with fifo_ready=1 -> first fifo_valid 1 cycle after req_valid; A0..A2 on consecutive cycles; busy drops after A2; rr_ptr=0.
- Both requesters continuously valid, 2-word packets -> grant order 0,1,0,1 with one bubble cycle between bursts; grant_id toggles accordingly.
- Requester 1 sends 10 words with no last, MAX_BURST=4 -> split into bursts of 4,4,2 only when requester 0 is idle; if requester 0 is valid, it is interleaved after each 4-word burst.
- fifo_ready held low for 20 cycles mid-burst -> fifo_valid stays 1, data stable, no timeout, beat_cnt frozen; burst resumes when ready returns.
- Granted requester drops valid after 1 word and stays low -> grant released after exactly IDLE_TIMEOUT (8) cycles; the other valid requester is granted next.
- Assert rst during the 2nd word of a burst -> fifo_valid=0, req_ready=0, busy=0, grant_id=0 immediately; after release, requester 0 has priority.

Source files
------------

// File: rtl/spi_slave_tx_arbiter.sv
// Round-robin arbiter sharing the SPI slave TX FIFO write port among NUM_REQ requesters.
// A grant lasts until a last flag, MAX_BURST words, or IDLE_TIMEOUT idle cycles.
module spi_slave_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MAX_BURST    = 4,
    parameter int unsigned IDLE_TIMEOUT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic                          fifo_valid,
    input  logic                          fifo_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned IdW   = $clog2(NUM_REQ);
    localparam int unsigned BeatW = $clog2(MAX_BURST + 1);
    localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [BeatW-1:0] BeatMax = BeatW'(MAX_BURST - 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IDLE_TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;

    logic             found;
    logic [IdW-1:0]   pick;
    logic             sel_valid;
    logic             sel_last;
    logic             xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= IdW'(NUM_REQ - 1);
            grant_q    <= '0;
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Search rr_ptr+1, rr_ptr+2, ... ; the outer loop order makes the nearest index win.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!found && req_valid[i] &&
                    rr_ptr_q == IdW'((i + int'(NUM_REQ) - k) % int'(NUM_REQ))) begin
                    found = 1'b1;
                    pick  = IdW'(i);
                end
            end
        end
    end

    always_comb begin
        fifo_data = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == IdW'(i)) begin
                fifo_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                req_ready[i] = (state_q == StGrant) && fifo_ready;
            end
        end
        fifo_valid = (state_q == StGrant) && sel_valid;
        busy       = (state_q == StGrant);
        grant_id   = grant_q;
        xfer       = fifo_valid && fifo_ready;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d    = pick;
                    state_d    = StGrant;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            StGrant: begin
                if (xfer) begin
                    if (sel_last || beat_cnt_q == BeatMax) begin
                        state_d  = StIdle;
                        rr_ptr_d = grant_q;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
                // Valid high (even when stalled by the FIFO) keeps the timeout at bay.
                if (sel_valid) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IdleMax) begin
                    state_d  = StIdle;
                    rr_ptr_d = grant_q;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_spi_slave_tx_arbiter.sv
// Randomized bench for spi_slave_tx_arbiter: requester drivers plus a transaction-level
// reference model of grants, bursts and timeouts, compared every cycle.
module tb_spi_slave_tx_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int IT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     fifo_data;
    logic              fifo_valid;
    logic              fifo_ready;
    logic [$clog2(N)-1:0] grant_id;
    logic              busy;

    always #5 clk = ~clk;

    spi_slave_tx_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (IT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_data   (req_data),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_data  (fifo_data),
        .fifo_valid (fifo_valid),
        .fifo_ready (fifo_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    // Requester drivers: current word, sequence number, idle gap, accepted last cycle.
    int          seq   [N];
    logic [DW-1:0] wdata [N];
    logic        wlast [N];
    int          gap   [N];
    bit          acc   [N];
    int          recv  [N];

    // Reference model: current grantee (-1 = none), last winner, visible grant id,
    // words sent in this burst, consecutive cycles the grantee has been idle.
    int mg, mrr, mgid, mwords, mlow;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic new_word(input int i);
        wdata[i] = {8'(i), 24'(seq[i])};
        wlast[i] = ($urandom_range(2) == 0);
    endtask

    task automatic reset_model();
        mg     = -1;
        mrr    = N - 1;
        mgid   = 0;
        mwords = 0;
        mlow   = 0;
    endtask

    task automatic step(input int ready_pct, input int gap_pct);
        logic          exp_valid;
        logic [N-1:0]  exp_ready;
        int            pick;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                seq[i]++;
                new_word(i);
                if ($urandom_range(99) < gap_pct) gap[i] = $urandom_range(1, 12);
            end
            if (gap[i] > 0) begin
                req_valid[i] = 1'b0;
                gap[i]--;
            end else begin
                req_valid[i] = 1'b1;
            end
            req_data[i*DW +: DW] = wdata[i];
            req_last[i] = wlast[i];
        end
        fifo_ready = ($urandom_range(99) < ready_pct);
        #1;
        exp_valid = (mg >= 0) ? req_valid[mg] : 1'b0;
        exp_ready = '0;
        if (mg >= 0) exp_ready[mg] = fifo_ready;
        check_eq("fifo_valid", 64'(fifo_valid), 64'(exp_valid));
        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("busy", 64'(busy), 64'(mg >= 0));
        check_eq("grant_id", 64'(grant_id), 64'(mgid));
        if (exp_valid) check_eq("fifo_data", 64'(fifo_data), 64'(wdata[mg]));

        for (int i = 0; i < N; i++) acc[i] = 1'b0;
        if (mg < 0) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                if (pick < 0 && req_valid[(mrr + k) % N]) pick = (mrr + k) % N;
            end
            if (pick >= 0) begin
                mg     = pick;
                mgid   = pick;
                mwords = 0;
                mlow   = 0;
            end
        end else if (req_valid[mg]) begin
            mlow = 0;
            if (fifo_ready) begin
                acc[mg] = 1'b1;
                recv[mg]++;
                mwords++;
                if (wlast[mg] || mwords == MB) begin
                    mrr = mg;
                    mg  = -1;
                end
            end
        end else begin
            mlow++;
            if (mlow == IT) begin
                mrr = mg;
                mg  = -1;
            end
        end
    endtask

    task automatic check_in_reset();
        check_eq("rst_fifo_valid", 64'(fifo_valid), 64'(0));
        check_eq("rst_req_ready", 64'(req_ready), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_grant_id", 64'(grant_id), 64'(0));
    endtask

    initial begin
        int waited;
        rst        = 1'b1;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        fifo_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            seq[i]  = 0;
            gap[i]  = 0;
            acc[i]  = 1'b0;
            recv[i] = 0;
            new_word(i);
        end
        reset_model();
        repeat (3) @(negedge clk);
        #1 check_in_reset();
        @(negedge clk);
        rst = 1'b0;

        repeat (400) step(90, 10);
        repeat (300) step(100, 0);
        repeat (400) step(50, 30);
        repeat (200) step(100, 60);

        // Long FIFO stall: valid and data must hold and no timeout may fire.
        waited = 0;
        while (!(mg >= 0 && mwords >= 1) && waited < 200) begin
            step(100, 0);
            waited++;
        end
        check_eq("reach_stall_point", 64'(mg >= 0), 64'(1));
        repeat (20) step(0, 0);
        repeat (100) step(100, 20);

        // Reset in the middle of a burst, with the second word in flight.
        waited = 0;
        while (!(mg >= 0 && mwords == 1) && waited < 200) begin
            step(100, 0);
            waited++;
        end
        check_eq("reach_mid_burst", 64'(mg >= 0 && mwords == 1), 64'(1));
        @(negedge clk);
        rst       = 1'b1;
        #1 check_in_reset();
        req_valid = '0;
        @(negedge clk);
        #1 check_in_reset();
        rst = 1'b0;
        reset_model();

        repeat (300) step(80, 15);
        check_eq("req0_words_seen", 64'(recv[0] > 0), 64'(1));
        check_eq("req1_words_seen", 64'(recv[1] > 0), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
